axi_mem_master: RTL

// - AXI4 initiator: turns one simple request (addr, beat count, rd/wr) into a single INCR burst on a 64-bit AXI4 bus.
// - Counterpart of the on-chip AXI memory slave; used by the core side and test DMA to reach axi-attached RAM.
// - One transaction outstanding at a time; read data and write data stream through with valid/ready.

---
 rtl/axi_mem_master_if.sv | 69 ++++++
 rtl/axi_mem_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/axi_mem_master_if.sv
// AXI4 bus bundle between axi_mem_master and an AXI memory slave.
// Carries the five channels (AW, W, B, AR, R) with a 64-bit data path and
// 32-bit addresses. The id width is set by ID_WIDTH.
// Modports:
//   master - drives AW/W/AR payload and valids, bready, rready
//   slave  - drives awready, wready, B channel, arready, R channel
interface axi_mem_master_if #(
  parameter int ID_WIDTH = 1
);
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [63:0]         wdata;
  logic [7:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [63:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_master.sv
// AXI4 initiator: converts one request (addr, beats-1, rd/wr) into a single
// 64-bit INCR burst. One transaction in flight; read and write beats stream
// straight through between the local valid/ready ports and the AXI bus.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req_*/o_req_ready      request handshake (we, addr, len=beats-1)
//   i_wd_*/o_wd_ready        write beat stream into the W channel
//   o_rd_*/i_rd_ready        read beat stream out of the R channel
//   o_done, o_err            completion pulse and its error flag
//   axi                      AXI4 master side (axi_mem_master_if.master)
//
// state | meaning
// IDLE  | ready for a request; 4KB-crossing requests complete here with error
// AR    | read address offered, waiting for arready
// R     | read beats passing through until the rlast handshake
// AW_W  | write address offered (until accepted) while W beats pass through
// B     | address and all W beats done, waiting for bvalid
module axi_mem_master #(
  parameter int ID_WIDTH = 1,
  parameter int AXI_ID   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [7:0]  i_req_len,
  input  logic [63:0] i_wd_data,
  input  logic [7:0]  i_wd_strb,
  input  logic        i_wd_valid,
  output logic        o_wd_ready,
  output logic [63:0] o_rd_data,
  output logic        o_rd_last,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic        o_done,
  output logic        o_err,
  axi_mem_master_if.master axi
);
  localparam logic [ID_WIDTH-1:0] ID_VAL = ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_t;
  state_t state_q, state_d;

  logic [28:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        err_q;
  logic        done_q;

  logic        accept;
  logic        cross_4k;
  logic [9:0]  end_beat;
  logic        r_hs, w_hs, w_last_hs, aw_hs, b_hs;
  logic        r_err, b_err;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^i_req_addr[2:0];

  assign accept   = i_req_valid && (state_q == S_IDLE);
  // Index of the last beat within the 4KB page; past 511 the burst would wrap the page.
  assign end_beat = {1'b0, i_req_addr[11:3]} + {2'b00, i_req_len};
  assign cross_4k = end_beat > 10'd511;

  assign r_hs      = (state_q == S_R) && axi.rvalid && i_rd_ready;
  assign w_hs      = (state_q == S_AW_W) && !w_done_q && i_wd_valid && axi.wready;
  assign w_last_hs = w_hs && (cnt_q == len_q);
  assign aw_hs     = (state_q == S_AW_W) && !aw_done_q && axi.awready;
  assign b_hs      = (state_q == S_B) && axi.bvalid;

  // rlast must coincide exactly with the final expected beat.
  assign r_err = (axi.rresp != 2'b00) || (axi.rid != ID_VAL) || (axi.rlast != (cnt_q == len_q));
  assign b_err = (axi.bresp != 2'b00) || (axi.bid != ID_VAL);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && !cross_4k) state_d = i_req_we ? S_AW_W : S_AR;
      S_AR:   if (axi.arready) state_d = S_R;
      S_R:    if (r_hs && axi.rlast) state_d = S_IDLE;
      S_AW_W: if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) state_d = S_B;
      S_B:    if (axi.bvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state_q == S_IDLE);
    axi.arvalid = (state_q == S_AR);
    axi.awvalid = (state_q == S_AW_W) && !aw_done_q;
    axi.wvalid  = (state_q == S_AW_W) && !w_done_q && i_wd_valid;
    o_wd_ready  = (state_q == S_AW_W) && !w_done_q && axi.wready;
    axi.bready  = (state_q == S_B);
    axi.rready  = (state_q == S_R) && i_rd_ready;
    o_rd_valid  = (state_q == S_R) && axi.rvalid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (accept && cross_4k) || (r_hs && axi.rlast) || b_hs;
      if (accept) begin
        addr_q    <= i_req_addr[31:3];
        len_q     <= i_req_len;
        cnt_q     <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        err_q     <= cross_4k;
      end else begin
        if (r_hs || w_hs) cnt_q <= cnt_q + 8'd1;
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_last_hs) w_done_q <= 1'b1;
        if ((r_hs && r_err) || (b_hs && b_err)) err_q <= 1'b1;
      end
    end
  end

  assign axi.awid    = ID_VAL;
  assign axi.awaddr  = {addr_q, 3'b000};
  assign axi.awlen   = len_q;
  assign axi.awsize  = 3'b011;
  assign axi.awburst = 2'b01;
  assign axi.wdata   = i_wd_data;
  assign axi.wstrb   = i_wd_strb;
  assign axi.wlast   = (cnt_q == len_q);
  assign axi.arid    = ID_VAL;
  assign axi.araddr  = {addr_q, 3'b000};
  assign axi.arlen   = len_q;
  assign axi.arsize  = 3'b011;
  assign axi.arburst = 2'b01;

  assign o_rd_data = axi.rdata;
  assign o_rd_last = axi.rlast;
  assign o_done    = done_q;
  // err_q still holds the finished transaction's status during the done cycle,
  // even if a new request is accepted in that same cycle.
  assign o_err     = done_q && err_q;
endmodule
